// File: rtl/stream_block_serializer_pkg.sv
// Shared definitions for the block serializer datapath.
// Contents:
//   BLOCK_DIM     - coefficients per row/column of a block
//   IdxWidth      - width of the row/column counter
//   LastIdx       - counter value of the final beat of a block
//   coef_row_t    - one packed row at the default coefficient width
//   coef_block_t  - one packed 8x8 block at the default coefficient width
//   state_e       - serializer control states
package stream_block_serializer_pkg;

  localparam int unsigned BLOCK_DIM        = 8;
  localparam int unsigned IdxWidth         = 3;
  localparam int unsigned CoefWidthDefault = 16;

  localparam logic [IdxWidth-1:0] LastIdx = 3'd7;

  typedef logic [BLOCK_DIM-1:0][CoefWidthDefault-1:0] coef_row_t;
  typedef logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][CoefWidthDefault-1:0] coef_block_t;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

endpackage

// File: rtl/block_row_select.sv
// Combinational row/column picker for an 8x8 coefficient block.
// Element [r][c] of the block sits at block_i[(r*8+c)*COEF_WIDTH +: COEF_WIDTH].
// Ports:
//   block_i - full block, 64 coefficients
//   idx_i   - row (COLUMN_ORDER=0) or column (COLUMN_ORDER=1) to pick
//   row_o   - picked line; element k at row_o[k*COEF_WIDTH +: COEF_WIDTH]
module block_row_select
  import stream_block_serializer_pkg::*;
#(
  parameter int unsigned COEF_WIDTH   = 16,
  parameter int unsigned COLUMN_ORDER = 0
) (
  input  logic [BLOCK_DIM*BLOCK_DIM*COEF_WIDTH-1:0] block_i,
  input  logic [IdxWidth-1:0]                       idx_i,
  output logic [BLOCK_DIM*COEF_WIDTH-1:0]           row_o
);

  always_comb begin
    int unsigned sel;
    sel   = 32'(idx_i);
    row_o = '0;
    for (int unsigned k = 0; k < BLOCK_DIM; k++) begin
      if (COLUMN_ORDER != 0) begin
        row_o[k*COEF_WIDTH +: COEF_WIDTH] = block_i[(k*BLOCK_DIM + sel)*COEF_WIDTH +: COEF_WIDTH];
      end else begin
        row_o[k*COEF_WIDTH +: COEF_WIDTH] = block_i[(sel*BLOCK_DIM + k)*COEF_WIDTH +: COEF_WIDTH];
      end
    end
  end

endmodule

// File: rtl/stream_block_serializer.sv
// Serializes one 8x8 coefficient block (one wide stream beat) into eight narrow
// row beats, or column beats when COLUMN_ORDER=1. One block is held at a time;
// the next block is accepted on the handshake of the final beat, so output runs
// at one beat per cycle with no bubble between blocks.
// Ports:
//   aclk, areset        - clock, synchronous active-high reset
//   in_t_*              - block input stream (slave); t_last is not needed since
//                         every input beat is a complete block
//   out_t_*             - row/column output stream (master)
module stream_block_serializer
  import stream_block_serializer_pkg::*;
#(
  parameter int unsigned COEF_WIDTH   = 16,
  parameter int unsigned COLUMN_ORDER = 0,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned DestWidth    = 4,
  parameter int unsigned UserWidth    = 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  // block input
  input  logic                      in_t_valid_i,
  output logic                      in_t_ready_o,
  input  logic [64*COEF_WIDTH-1:0]  in_t_data_i,
  input  logic [8*COEF_WIDTH-1:0]   in_t_keep_i,
  input  logic [8*COEF_WIDTH-1:0]   in_t_strb_i,
  input  logic [IdWidth-1:0]        in_t_id_i,
  input  logic [DestWidth-1:0]      in_t_dest_i,
  input  logic [UserWidth-1:0]      in_t_user_i,
  // row output
  output logic                      out_t_valid_o,
  input  logic                      out_t_ready_i,
  output logic [8*COEF_WIDTH-1:0]   out_t_data_o,
  output logic [COEF_WIDTH-1:0]     out_t_keep_o,
  output logic [COEF_WIDTH-1:0]     out_t_strb_o,
  output logic [IdWidth-1:0]        out_t_id_o,
  output logic [DestWidth-1:0]      out_t_dest_o,
  output logic [UserWidth-1:0]      out_t_user_o,
  output logic                      out_t_last_o
);

  state_e                    state_q, state_d;
  logic [IdxWidth-1:0]       idx_q, idx_d;
  logic [64*COEF_WIDTH-1:0]  data_q;
  logic [8*COEF_WIDTH-1:0]   keep_q, strb_q;
  logic [IdWidth-1:0]        id_q;
  logic [DestWidth-1:0]      dest_q;
  logic [UserWidth-1:0]      user_q;

  logic load;
  logic in_hs, out_hs;
  logic on_last;

  assign on_last = (idx_q == LastIdx);

  always_comb begin
    out_t_valid_o = (state_q == StSend);
    out_t_last_o  = out_t_valid_o && on_last;
    // Only combinational ready path: the final beat's downstream ready frees the slot.
    in_t_ready_o  = (state_q == StIdle) || (out_t_valid_o && on_last && out_t_ready_i);
    in_hs         = in_t_valid_i && in_t_ready_o;
    out_hs        = out_t_valid_o && out_t_ready_i;

    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_hs) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (out_hs) begin
          if (!on_last) begin
            idx_d = idx_q + 3'd1;
          end else begin
            idx_d = '0;
            if (in_hs) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      strb_q  <= '0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        data_q <= in_t_data_i;
        keep_q <= in_t_keep_i;
        strb_q <= in_t_strb_i;
        id_q   <= in_t_id_i;
        dest_q <= in_t_dest_i;
        user_q <= in_t_user_i;
      end
    end
  end

  block_row_select #(
    .COEF_WIDTH  (COEF_WIDTH),
    .COLUMN_ORDER(COLUMN_ORDER)
  ) u_row_select (
    .block_i(data_q),
    .idx_i  (idx_q),
    .row_o  (out_t_data_o)
  );

  // A column spans every row, so no single row's keep/strb slice applies to it.
  always_comb begin
    if (COLUMN_ORDER != 0) begin
      out_t_keep_o = '1;
      out_t_strb_o = '1;
    end else begin
      out_t_keep_o = keep_q[32'(idx_q)*COEF_WIDTH +: COEF_WIDTH];
      out_t_strb_o = strb_q[32'(idx_q)*COEF_WIDTH +: COEF_WIDTH];
    end
  end

  assign out_t_id_o   = id_q;
  assign out_t_dest_o = dest_q;
  assign out_t_user_o = user_q;

endmodule

// File: tb/tb_stream_block_serializer.sv
module tb_stream_block_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          in_v;
  logic          out_r;
  logic [1023:0] in_data;
  logic [127:0]  in_keep, in_strb;
  logic [3:0]    in_id, in_dest;
  logic          in_user;

  logic          ir0, ov0, last0, user0;
  logic [127:0]  data0;
  logic [15:0]   keep0, strb0;
  logic [3:0]    id0, dest0;
  logic          ir1, ov1, last1, user1;
  logic [127:0]  data1;
  logic [15:0]   keep1, strb1;
  logic [3:0]    id1, dest1;

  stream_block_serializer #(
    .COEF_WIDTH(16), .COLUMN_ORDER(0), .IdWidth(4), .DestWidth(4), .UserWidth(1)
  ) u_dut_row (
    .aclk(clk), .areset(areset),
    .in_t_valid_i(in_v), .in_t_ready_o(ir0), .in_t_data_i(in_data), .in_t_keep_i(in_keep),
    .in_t_strb_i(in_strb), .in_t_id_i(in_id), .in_t_dest_i(in_dest), .in_t_user_i(in_user),
    .out_t_valid_o(ov0), .out_t_ready_i(out_r), .out_t_data_o(data0), .out_t_keep_o(keep0),
    .out_t_strb_o(strb0), .out_t_id_o(id0), .out_t_dest_o(dest0), .out_t_user_o(user0),
    .out_t_last_o(last0)
  );

  stream_block_serializer #(
    .COEF_WIDTH(16), .COLUMN_ORDER(1), .IdWidth(4), .DestWidth(4), .UserWidth(1)
  ) u_dut_col (
    .aclk(clk), .areset(areset),
    .in_t_valid_i(in_v), .in_t_ready_o(ir1), .in_t_data_i(in_data), .in_t_keep_i(in_keep),
    .in_t_strb_i(in_strb), .in_t_id_i(in_id), .in_t_dest_i(in_dest), .in_t_user_i(in_user),
    .out_t_valid_o(ov1), .out_t_ready_i(out_r), .out_t_data_o(data1), .out_t_keep_o(keep1),
    .out_t_strb_o(strb1), .out_t_id_o(id1), .out_t_dest_o(dest1), .out_t_user_o(user1),
    .out_t_last_o(last1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: queue of every beat still owed downstream, for both orderings.
  typedef struct {
    logic [127:0] drow;
    logic [127:0] dcol;
    logic [15:0]  keep;
    logic [15:0]  strb;
    logic [3:0]   id;
    logic [3:0]   dest;
    logic         user;
    bit           last;
  } beat_t;

  beat_t q[$];

  task automatic push_block();
    for (int r = 0; r < 8; r++) begin
      beat_t b;
      for (int k = 0; k < 8; k++) begin
        b.drow[k*16 +: 16] = in_data[(r*8 + k)*16 +: 16];
        b.dcol[k*16 +: 16] = in_data[(k*8 + r)*16 +: 16];
      end
      b.keep = in_keep[r*16 +: 16];
      b.strb = in_strb[r*16 +: 16];
      b.id   = in_id;
      b.dest = in_dest;
      b.user = in_user;
      b.last = (r == 7);
      q.push_back(b);
    end
  endtask

  // Called just after a negedge with inputs already driven; compares, then
  // advances the reference across the following posedge.
  task automatic step();
    bit ev, er;
    #1;
    ev = (q.size() != 0);
    er = (q.size() == 0) || (q.size() == 1 && out_r);
    chk("row_in_ready", ir0, er);
    chk("col_in_ready", ir1, er);
    chk("row_out_valid", ov0, ev);
    chk("col_out_valid", ov1, ev);
    if (ev) begin
      chk("row_data", data0, q[0].drow);
      chk("col_data", data1, q[0].dcol);
      chk("row_keep", keep0, q[0].keep);
      chk("row_strb", strb0, q[0].strb);
      chk("col_keep", keep1, 16'hffff);
      chk("col_strb", strb1, 16'hffff);
      chk("row_last", last0, q[0].last);
      chk("col_last", last1, q[0].last);
      chk("row_side", {user0, dest0, id0}, {q[0].user, q[0].dest, q[0].id});
      chk("col_side", {user1, dest1, id1}, {q[0].user, q[0].dest, q[0].id});
    end else begin
      chk("row_last_idle", last0, 1'b0);
      chk("col_last_idle", last1, 1'b0);
    end
    if (areset) begin
      q.delete();
    end else begin
      if (ev && out_r) void'(q.pop_front());
      if (in_v && er) push_block();
    end
    @(negedge clk);
  endtask

  task automatic rand_block();
    for (int i = 0; i < 32; i++) in_data[i*32 +: 32] = $urandom();
    for (int i = 0; i < 4; i++) begin
      in_keep[i*32 +: 32] = ($urandom_range(0, 1) != 0) ? 32'hffff_ffff : $urandom();
      in_strb[i*32 +: 32] = $urandom();
    end
    in_id   = 4'($urandom());
    in_dest = 4'($urandom());
    in_user = 1'($urandom());
  endtask

  typedef struct {
    bit          in_v;
    bit          out_r;
    bit          exp_ov;
    bit          exp_ir;
    bit          exp_last;
    logic [15:0] e0_row;
    logic [15:0] e0_col;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [127:0] col0_exp;
    col0_exp = 128'h0070_0060_0050_0040_0030_0020_0010_0000;

    // single block with a 3-cycle stall on beat 4
    tbl[0]  = '{1, 1, 0, 1, 0, 16'h00, 16'h0};
    tbl[1]  = '{0, 1, 1, 0, 0, 16'h00, 16'h0};
    tbl[2]  = '{0, 1, 1, 0, 0, 16'h10, 16'h1};
    tbl[3]  = '{0, 1, 1, 0, 0, 16'h20, 16'h2};
    tbl[4]  = '{0, 1, 1, 0, 0, 16'h30, 16'h3};
    tbl[5]  = '{0, 0, 1, 0, 0, 16'h40, 16'h4};
    tbl[6]  = '{0, 0, 1, 0, 0, 16'h40, 16'h4};
    tbl[7]  = '{0, 0, 1, 0, 0, 16'h40, 16'h4};
    tbl[8]  = '{0, 1, 1, 0, 0, 16'h40, 16'h4};
    tbl[9]  = '{0, 1, 1, 0, 0, 16'h50, 16'h5};
    tbl[10] = '{0, 1, 1, 0, 0, 16'h60, 16'h6};
    tbl[11] = '{0, 1, 1, 1, 1, 16'h70, 16'h7};
    tbl[12] = '{0, 1, 0, 1, 0, 16'h00, 16'h0};

    areset  = 1'b1;
    in_v    = 1'b0;
    out_r   = 1'b1;
    in_data = '0;
    in_keep = '1;
    in_strb = '1;
    in_id   = '0;
    in_dest = '0;
    in_user = 1'b0;
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    #1;
    chk("reset_row_valid", ov0, 1'b0);
    chk("reset_row_last", last0, 1'b0);
    chk("reset_row_data", data0, '0);
    chk("reset_col_data", data1, '0);
    chk("reset_in_ready", ir0, 1'b1);

    // table-driven single block, element [r][c] = 16*r+c
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) in_data[(r*8 + c)*16 +: 16] = 16'(16*r + c);
    for (int i = 0; i < 13; i++) begin
      in_v  = tbl[i].in_v;
      out_r = tbl[i].out_r;
      #1;
      chk("tbl_out_valid", ov0, tbl[i].exp_ov);
      chk("tbl_in_ready", ir0, tbl[i].exp_ir);
      chk("tbl_last", last0, tbl[i].exp_last);
      if (tbl[i].exp_ov) begin
        chk("tbl_row_e0", data0[15:0], tbl[i].e0_row);
        chk("tbl_col_e0", data1[15:0], tbl[i].e0_col);
      end
      if (i == 1) chk("col_beat0_full", data1, col0_exp);
      step();
    end

    // back-to-back blocks with input valid held high
    in_v  = 1'b1;
    out_r = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_block();
      step();
    end
    in_v = 1'b0;
    for (int i = 0; i < 9; i++) step();

    // sideband: row 1 keep zeroed
    in_v    = 1'b1;
    in_id   = 4'd3;
    in_dest = 4'd5;
    in_user = 1'b1;
    in_keep = '1;
    in_keep[31:16] = '0;
    step();
    in_v = 1'b0;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("sb_id", id0, 4'd3);
      chk("sb_dest", dest0, 4'd5);
      chk("sb_user", user0, 1'b1);
      chk("sb_keep", keep0, (b == 1) ? 16'h0000 : 16'hffff);
      step();
    end
    step();

    // reset mid-block after beat 2
    rand_block();
    in_v = 1'b1;
    step();
    in_v = 1'b0;
    for (int i = 0; i < 3; i++) step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
    chk("midrst_out_valid", ov0, 1'b0);
    chk("midrst_in_ready", ir0, 1'b1);
    rand_block();
    in_v = 1'b1;
    step();
    in_v = 1'b0;
    for (int i = 0; i < 9; i++) step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_block();
      in_v   = ($urandom_range(0, 9) < 7);
      out_r  = ($urandom_range(0, 9) < 7);
      areset = ($urandom_range(0, 199) == 0);
      step();
    end
    areset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_block_serializer.md
# stream_block_serializer

Serializes one 8x8 coefficient block, carried as a single wide beat on a NASTI stream, into eight narrow row beats. Optionally emits columns instead of rows. It sits at the transmit end of the block datapath, after the block-wide transpose stage, and feeds row-serial consumers such as the entropy coder and the writeback DMA. Its data path is a one-block holding register plus a row counter, and it sustains one output beat per cycle with no bubble between blocks.

## Interface
- COEF_WIDTH, 16, bits per coefficient; input beat is 64*COEF_WIDTH bits, output beat is 8*COEF_WIDTH bits
- COLUMN_ORDER, 0, 0 emits rows; 1 emits columns (transposed serialization)
- aclk  input  1  clock
- areset  input  1  reset, synchronous, active-high
- in_ch  nasti_stream_channel.slave  t_data 64*COEF_WIDTH  one full block per beat; element [r][c] is at t_data[(r*8+c)*COEF_WIDTH +: COEF_WIDTH]
- out_ch  nasti_stream_channel.master  t_data 8*COEF_WIDTH  one row (or column) per beat; element k is at t_data[k*COEF_WIDTH +: COEF_WIDTH]

## Operation
- States:
  - IDLE: holding register empty.
  - SEND: holding register full; row counter idx runs 0..7.
- IDLE:
  - in_ch.t_ready = 1.
  - On in handshake: latch t_data, t_keep, t_strb, t_id, t_dest, t_user; set idx=0; go to SEND.
- SEND:
  - out_ch.t_valid = 1.
  - out t_data:
    - COLUMN_ORDER=0: out element k = block[idx][k].
    - COLUMN_ORDER=1: out element k = block[k][idx].
  - out t_keep/t_strb:
    - COLUMN_ORDER=0: the latched input slice for row idx, i.e. bits [idx*COEF_WIDTH*... ] covering row idx's bytes (COEF_WIDTH bytes per row).
    - COLUMN_ORDER=1: all ones.
  - out t_id/t_dest/t_user: latched values, constant for all 8 beats.
  - out t_last = (idx==7).
  - On out handshake with idx<7: idx increments.
  - On out handshake with idx==7, and an in handshake in the same cycle: latch the new block, idx=0, stay in SEND.
  - On out handshake with idx==7 and no new block: go to IDLE.
- in_ch.t_ready = IDLE || (SEND && idx==7 && out_ch.t_ready). This is the only combinational ready path, and it runs out→in.
- Input t_last is ignored; every input beat is one complete block.
- Stall: while out_ch.t_ready=0, out t_valid, t_data and sideband hold stable and idx does not change.

## Timing
- Reset values (areset high at a clock edge):
  - state=IDLE, idx=0, holding register cleared to 0.
  - out_ch.t_valid=0, t_last=0, t_data=0.
  - in_ch.t_ready=1 on the first cycle after reset deasserts.
- Reset mid-block: the partial block is discarded and no further beats are emitted. The upstream beat is not replayed.
- Latency: an input handshake at edge N presents row 0 on out_ch from cycle N+1.
- Throughput: 8 output beats per block. With out_ch.t_ready held at 1 and in_ch.t_valid held at 1, output is continuous at 1 beat/cycle and the input accepts one block every 8 cycles.
- The input handshake happens only on the cycle of the final-row output handshake, or in IDLE. There is never more than one block held.

## Structure
- Shared package (e.g. videox_pkg) holds:
  - BLOCK_DIM=8.
  - typedef coef_row_t = logic [7:0][COEF_WIDTH-1:0] (packed row).
  - typedef coef_block_t = logic [7:0][7:0][COEF_WIDTH-1:0].
  - State enum {IDLE, SEND}.
- The row/column select mux is a natural sub-module, block_row_select. It is combinational: block, idx and COLUMN_ORDER in, row out. It is also reusable by the row-serial deserializer.
- Control (state, idx, ready) stays in the top module.

## Test plan
- Single block, COLUMN_ORDER=0, element [r][c]=16*r+c, out_ch.t_ready=1:
  - 8 beats on cycles N+1..N+8.
  - Beat r element k = 16*r+k.
  - t_last only on beat 7.
  - in_ch.t_ready=0 during beats 0..6.
- Same block with COLUMN_ORDER=1:
  - Beat c element k = 16*k+c.
  - Beat 0 = {0x70,0x60,...,0x00} (element 7..0).
  - t_keep all ones.
- Back-to-back blocks A then B with in t_valid held high:
  - 16 consecutive beats, no idle cycle.
  - B is accepted on the same cycle as A's beat 7 handshake.
  - B row 0 appears the next cycle.
- Backpressure: deassert out_ch.t_ready for 3 cycles on beat 4:
  - t_data, t_last=0 and t_id stay stable.
  - idx stays at 4.
  - Resume yields beats 4..7 in order.
- Reset mid-block: assert areset after beat 2:
  - Next cycle out t_valid=0 and in t_ready=1.
  - A new block then emits starting at row 0.
- Sideband: input t_id=3, t_dest=5, t_user=1, t_keep row-1 slice zeroed:
  - All 8 beats carry id 3, dest 5, user 1.
  - Beat 1 t_keep=0, others all ones.
